// File: rtl/rs_encode_stream_in_ctrl_mc.sv
// Purpose : input controller for the multi-unit RS stream encoder; turns request
//           descriptors into data + generated pad lines dealt round-robin to RS units.
// Latency : combinational line handshake (line_val follows src_data_val/unit_rdy same cycle);
//           metadata token valid the cycle after a request is accepted.
// Backpr. : unit_rdy of the selected unit stalls the line stream (and src_data_rdy);
//           meta_rdy stalls only the token; new requests wait for the token to drain
//           and for fewer than MAX_OUTSTANDING requests to be in flight.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   src_req_*                   request descriptor handshake + fields
//   src_data_val/src_data_rdy   incoming data line handshake
//   line_val/pad/last, unit_sel line presented to the selected RS unit
//   unit_rdy                    per-unit ready
//   meta_*                      one token per request to the output controller
//   out_req_done                pulse: output side retired one request

module rs_encode_stream_in_ctrl_mc #(
   parameter int NUM_RS_UNITS    = 4,
   parameter int NUM_RS_UNITS_W  = (NUM_RS_UNITS > 1) ? $clog2(NUM_RS_UNITS) : 1,
   parameter int LINES_W         = 8,
   parameter int BLOCKS_W        = 16,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      src_req_val,
   output logic                      src_req_rdy,
   input  logic [BLOCKS_W-1:0]       src_req_num_blocks,
   input  logic [LINES_W-1:0]        src_req_data_lines,
   input  logic [LINES_W-1:0]        src_req_pad_lines,
   input  logic                      src_data_val,
   output logic                      src_data_rdy,
   output logic                      line_val,
   output logic                      line_pad,
   output logic                      line_last,
   output logic [NUM_RS_UNITS_W-1:0] unit_sel,
   input  logic [NUM_RS_UNITS-1:0]   unit_rdy,
   output logic                      meta_val,
   input  logic                      meta_rdy,
   output logic [BLOCKS_W-1:0]       meta_num_blocks,
   output logic [NUM_RS_UNITS_W-1:0] meta_first_unit,
   input  logic                      out_req_done
);

   localparam int OUT_W = (MAX_OUTSTANDING > 0) ? $clog2(MAX_OUTSTANDING + 1) : 1;
   // one extra bit so data_lines + pad_lines cannot wrap
   localparam int CNT_W = LINES_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_PAD  = 2'd2
   } state_t;

   state_t                    state_q,           state_d;
   logic [BLOCKS_W-1:0]       num_blocks_q,      num_blocks_d;
   logic [LINES_W-1:0]        data_lines_q,      data_lines_d;
   logic [LINES_W-1:0]        pad_lines_q,       pad_lines_d;
   logic [CNT_W-1:0]          line_cnt_q,        line_cnt_d;
   logic [BLOCKS_W-1:0]       blk_cnt_q,         blk_cnt_d;
   logic [NUM_RS_UNITS_W-1:0] unit_sel_q,        unit_sel_d;
   logic                      meta_val_q,        meta_val_d;
   logic [BLOCKS_W-1:0]       meta_num_blocks_q, meta_num_blocks_d;
   logic [NUM_RS_UNITS_W-1:0] meta_first_unit_q, meta_first_unit_d;
   logic [OUT_W-1:0]          outstanding_q,     outstanding_d;

   logic                      sel_rdy;
   logic                      has_pad;
   logic                      data_end;
   logic                      pad_end;
   logic                      xfer;
   logic                      last_c;
   logic                      req_rdy_c;
   logic                      req_acc;
   logic                      done_eff;
   logic [LINES_W-1:0]        eff_data_lines;
   logic [NUM_RS_UNITS_W-1:0] unit_sel_inc;

   assign sel_rdy  = unit_rdy[unit_sel_q];
   assign has_pad  = (pad_lines_q != '0);
   assign data_end = (line_cnt_q == (CNT_W'(data_lines_q) - CNT_W'(1)));
   assign pad_end  = (line_cnt_q == (CNT_W'(data_lines_q) + CNT_W'(pad_lines_q) - CNT_W'(1)));

   // A descriptor with no data and no pad still has to produce a block, so it
   // is promoted to one data line per block.
   assign eff_data_lines = ((src_req_data_lines == '0) && (src_req_pad_lines == '0))
                           ? LINES_W'(1) : src_req_data_lines;

   assign unit_sel_inc = (unit_sel_q == NUM_RS_UNITS_W'(NUM_RS_UNITS - 1))
                         ? '0 : unit_sel_q + NUM_RS_UNITS_W'(1);

   // Gated by rst_n so the ready output reads 0 while reset is held, not just
   // once the flops have cleared.
   assign req_rdy_c = rst_n && (state_q == ST_IDLE) && !meta_val_q &&
                      (outstanding_q < OUT_W'(MAX_OUTSTANDING));
   assign req_acc   = src_req_val && req_rdy_c;
   assign done_eff  = out_req_done && (outstanding_q != '0);

   always_comb begin
      xfer   = 1'b0;
      last_c = 1'b0;
      case (state_q)
         ST_DATA: begin
            xfer   = src_data_val && sel_rdy;
            last_c = data_end && !has_pad;
         end
         ST_PAD: begin
            xfer   = sel_rdy;
            last_c = pad_end;
         end
         default: begin
            xfer   = 1'b0;
            last_c = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_d           = state_q;
      num_blocks_d      = num_blocks_q;
      data_lines_d      = data_lines_q;
      pad_lines_d       = pad_lines_q;
      line_cnt_d        = line_cnt_q;
      blk_cnt_d         = blk_cnt_q;
      unit_sel_d        = unit_sel_q;
      meta_val_d        = meta_val_q;
      meta_num_blocks_d = meta_num_blocks_q;
      meta_first_unit_d = meta_first_unit_q;
      outstanding_d     = outstanding_q;

      // Token drains independently of the line stream.
      if (meta_val_q && meta_rdy) begin
         meta_val_d = 1'b0;
      end

      if (req_acc && !done_eff) begin
         outstanding_d = outstanding_q + OUT_W'(1);
      end else if (!req_acc && done_eff) begin
         outstanding_d = outstanding_q - OUT_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (req_acc) begin
               num_blocks_d      = src_req_num_blocks;
               data_lines_d      = eff_data_lines;
               pad_lines_d       = src_req_pad_lines;
               line_cnt_d        = '0;
               blk_cnt_d         = '0;
               // req_acc implies the slot is empty, so no clash with the drain above
               meta_val_d        = 1'b1;
               meta_num_blocks_d = src_req_num_blocks;
               meta_first_unit_d = unit_sel_q;
               if (src_req_num_blocks == '0) begin
                  state_d = ST_IDLE;
               end else if (eff_data_lines == '0) begin
                  state_d = ST_PAD;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA, ST_PAD: begin
            if (xfer) begin
               if (last_c) begin
                  line_cnt_d = '0;
                  blk_cnt_d  = blk_cnt_q + BLOCKS_W'(1);
                  unit_sel_d = unit_sel_inc;
                  if (blk_cnt_q == (num_blocks_q - BLOCKS_W'(1))) begin
                     state_d = ST_IDLE;
                  end else if (data_lines_q == '0) begin
                     state_d = ST_PAD;
                  end else begin
                     state_d = ST_DATA;
                  end
               end else begin
                  line_cnt_d = line_cnt_q + CNT_W'(1);
                  if ((state_q == ST_DATA) && data_end) begin
                     state_d = ST_PAD;
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q           <= ST_IDLE;
         num_blocks_q      <= '0;
         data_lines_q      <= '0;
         pad_lines_q       <= '0;
         line_cnt_q        <= '0;
         blk_cnt_q         <= '0;
         unit_sel_q        <= '0;
         meta_val_q        <= 1'b0;
         meta_num_blocks_q <= '0;
         meta_first_unit_q <= '0;
         outstanding_q     <= '0;
      end else begin
         state_q           <= state_d;
         num_blocks_q      <= num_blocks_d;
         data_lines_q      <= data_lines_d;
         pad_lines_q       <= pad_lines_d;
         line_cnt_q        <= line_cnt_d;
         blk_cnt_q         <= blk_cnt_d;
         unit_sel_q        <= unit_sel_d;
         meta_val_q        <= meta_val_d;
         meta_num_blocks_q <= meta_num_blocks_d;
         meta_first_unit_q <= meta_first_unit_d;
         outstanding_q     <= outstanding_d;
      end
   end

   assign src_req_rdy     = req_rdy_c;
   assign src_data_rdy    = (state_q == ST_DATA) && sel_rdy;
   assign line_val        = (state_q == ST_PAD) || ((state_q == ST_DATA) && src_data_val && sel_rdy);
   assign line_pad        = (state_q == ST_PAD);
   assign line_last       = last_c;
   assign unit_sel        = unit_sel_q;
   assign meta_val        = meta_val_q;
   assign meta_num_blocks = meta_num_blocks_q;
   assign meta_first_unit = meta_first_unit_q;

endmodule
